// File: rtl/s386_bist_driver.sv
// LFSR stimulus generator and MISR response compactor for the s386 controller; start/done host handshake.
// Response is sampled in the same cycle its stimulus is driven; start is ignored while busy (LOAD/RUN).
module s386_bist_driver #(
  parameter int         CNTW    = 16,
  parameter logic [6:0] DEFSEED = 7'h01
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            start,
  input  logic [6:0]      seed,
  input  logic [CNTW-1:0] ncyc,
  output logic [6:0]      stim,
  input  logic [6:0]      resp,
  output logic            busy,
  output logic            done,
  output logic [6:0]      signature,
  output logic [CNTW-1:0] count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [6:0]      lfsr_q, lfsr_d;
  logic [6:0]      misr_q, misr_d;
  logic [6:0]      seed_r_q, seed_r_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] ncyc_r_q, ncyc_r_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            run_q, run_d;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    seed_r_d = seed_r_q;
    cnt_d    = cnt_q;
    ncyc_r_d = ncyc_r_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          ncyc_r_d = ncyc;
          seed_r_d = seed;
          if (ncyc == '0) begin
            state_d = DONE;
            misr_d  = '0;
            cnt_d   = '0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        // an all-zero seed would lock the LFSR at zero
        lfsr_d  = (seed_r_q == 7'h00) ? DEFSEED : seed_r_q;
        misr_d  = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        misr_d = {misr_q[5:0], misr_q[6] ^ misr_q[5]} ^ resp;
        cnt_d  = cnt_q + CNTW'(1);
        if (cnt_q == (ncyc_r_q - CNTW'(1))) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == RUN);
    done_d = (state_d == DONE);
    run_d  = (state_d == RUN);
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      lfsr_q   <= '0;
      misr_q   <= '0;
      seed_r_q <= '0;
      cnt_q    <= '0;
      ncyc_r_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      seed_r_q <= seed_r_d;
      cnt_q    <= cnt_d;
      ncyc_r_q <= ncyc_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      run_q    <= run_d;
    end
  end

  // stimulus is gated so the controller sees all zeros outside RUN
  assign stim      = run_q ? lfsr_q : 7'h00;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = misr_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_s386_bist_driver.sv
// Scoreboard bench for s386_bist_driver with a constant or stimulus-derived responder.
module tb_s386_bist_driver;
  localparam int CNTW = 16;

  logic            CK = 1'b0;
  logic            RST;
  logic            start;
  logic [6:0]      seed;
  logic [CNTW-1:0] ncyc;
  logic [6:0]      stim;
  logic [6:0]      resp;
  logic            busy;
  logic            done;
  logic [6:0]      signature;
  logic [CNTW-1:0] count;

  int checks   = 0;
  int failures = 0;

  bit         resp_mode  = 1'b0;
  logic [6:0] resp_const = 7'h00;

  logic [6:0] exp_stim_q[$];
  logic [6:0] exp_sig_q[$];
  logic [6:0] exp_final;
  int         exp_n;

  s386_bist_driver #(.CNTW(CNTW), .DEFSEED(7'h01)) dut (
    .CK(CK), .RST(RST), .start(start), .seed(seed), .ncyc(ncyc),
    .stim(stim), .resp(resp), .busy(busy), .done(done),
    .signature(signature), .count(count)
  );

  always #5 CK = ~CK;

  // Stand-in for the controller: combinational in its inputs when mode=1
  function automatic logic [6:0] responder(input logic [6:0] s, input bit mode, input logic [6:0] c);
    if (mode) return {s[0], s[6:1]} ^ 7'h35 ^ {s[3], 6'b000000};
    return c;
  endfunction

  always_comb resp = responder(stim, resp_mode, resp_const);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic sb_load(input logic [6:0] sd, input int n);
    logic [6:0] l;
    logic [6:0] m;
    exp_stim_q.delete();
    exp_sig_q.delete();
    l = (sd == 7'h00) ? 7'h01 : sd;
    m = 7'h00;
    for (int k = 0; k < n; k++) begin
      exp_stim_q.push_back(l);
      exp_sig_q.push_back(m);
      m = {m[5:0], m[6] ^ m[5]} ^ responder(l, resp_mode, resp_const);
      l = {l[5:0], l[6] ^ l[5]};
    end
    exp_final = m;
    exp_n     = n;
  endtask

  // Returns at the falling edge of the first cycle after the start is accepted
  task automatic start_run(input logic [6:0] sd, input int n);
    @(negedge CK);
    seed  = sd;
    ncyc  = CNTW'(n);
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
  endtask

  task automatic sb_drain(input string nm, output int busy_cycles, output logic [6:0] sig_out);
    logic [6:0] es;
    logic [6:0] eg;
    int k;
    busy_cycles = 0;
    k = 0;
    checks++;
    if (busy !== 1'b1 || stim !== 7'h00) begin
      failures++;
      $display("FAIL %s_load: busy=%b stim=%h, want busy=1 stim=00", nm, busy, stim);
    end
    if (busy === 1'b1) busy_cycles++;
    while (exp_stim_q.size() > 0) begin
      @(negedge CK);
      es = exp_stim_q.pop_front();
      eg = exp_sig_q.pop_front();
      if (busy === 1'b1) busy_cycles++;
      checks++;
      if (stim !== es) begin
        failures++;
        $display("FAIL %s_stim[%0d]: got %h want %h", nm, k, stim, es);
      end
      checks++;
      if (signature !== eg) begin
        failures++;
        $display("FAIL %s_sig[%0d]: got %h want %h", nm, k, signature, eg);
      end
      checks++;
      if (count !== CNTW'(k)) begin
        failures++;
        $display("FAIL %s_count[%0d]: got %0d want %0d", nm, k, count, k);
      end
      k++;
    end
    @(negedge CK);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || stim !== 7'h00) begin
      failures++;
      $display("FAIL %s_done: done=%b busy=%b stim=%h, want 1 0 00", nm, done, busy, stim);
    end
    checks++;
    if (signature !== exp_final) begin
      failures++;
      $display("FAIL %s_final_sig: got %h want %h", nm, signature, exp_final);
    end
    checks++;
    if (count !== CNTW'(exp_n)) begin
      failures++;
      $display("FAIL %s_final_count: got %0d want %0d", nm, count, exp_n);
    end
    sig_out = signature;
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; seed = 7'h00; ncyc = '0;
    repeat (2) @(negedge CK);
    checks++;
    if ({stim, busy, done, signature, count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: stim=%h busy=%b done=%b sig=%h count=%0d, want all 0",
               stim, busy, done, signature, count);
    end
    RST = 1'b0;
    repeat (2) @(negedge CK);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stim !== 7'h00) begin
      failures++;
      $display("FAIL reset_idle_hold: busy=%b done=%b stim=%h, want 0 0 00", busy, done, stim);
    end
  endtask

  task automatic test_zero_resp();
    int bc;
    logic [6:0] sg;
    resp_mode = 1'b0; resp_const = 7'h00;
    sb_load(7'h00, 4);
    start_run(7'h00, 4);
    sb_drain("zero_resp", bc, sg);
    checks++;
    if (bc !== 5) begin
      failures++;
      $display("FAIL zero_resp_busy_cycles: got %0d want 5", bc);
    end
    checks++;
    if (sg !== 7'h00 || count !== 16'd4) begin
      failures++;
      $display("FAIL zero_resp_result: sig=%h count=%0d, want 00 4", sg, count);
    end
  endtask

  task automatic test_ones_resp();
    int bc;
    logic [6:0] sg;
    resp_mode = 1'b0; resp_const = 7'h7F;
    sb_load(7'h00, 4);
    start_run(7'h00, 4);
    sb_drain("ones_resp", bc, sg);
    checks++;
    if (sg !== 7'h05 || count !== 16'h0004) begin
      failures++;
      $display("FAIL ones_resp_result: sig=%h count=%0d, want 05 4", sg, count);
    end
  endtask

  task automatic test_seed1_8();
    logic [6:0] tbl [8];
    tbl = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};
    resp_mode = 1'b0; resp_const = 7'h00;
    start_run(7'h01, 8);
    for (int k = 0; k < 8; k++) begin
      @(negedge CK);
      checks++;
      if (stim !== tbl[k]) begin
        failures++;
        $display("FAIL seed1_stim[%0d]: got %h want %h", k, stim, tbl[k]);
      end
    end
    @(negedge CK);
    checks++;
    if (done !== 1'b1 || count !== 16'd8) begin
      failures++;
      $display("FAIL seed1_done: done=%b count=%0d, want 1 8", done, count);
    end
  endtask

  task automatic test_start_ignored();
    int bc;
    logic [6:0] sg;
    resp_mode = 1'b0; resp_const = 7'h2C;
    sb_load(7'h03, 6);
    start_run(7'h03, 6);
    fork
      sb_drain("start_busy", bc, sg);
      begin
        seed  = 7'h55;
        ncyc  = CNTW'(2);
        start = 1'b1;
        repeat (3) @(negedge CK);
        start = 1'b0;
      end
    join
  endtask

  task automatic test_ncyc_zero();
    checks++;
    if (signature === 7'h00) begin
      failures++;
      $display("FAIL ncyc0_precondition: sig=%h, want nonzero before restart", signature);
    end
    start_run(7'h11, 0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || signature !== 7'h00 || count !== '0 || stim !== 7'h00) begin
      failures++;
      $display("FAIL ncyc0_done: done=%b busy=%b sig=%h count=%0d stim=%h, want 1 0 00 0 00",
               done, busy, signature, count, stim);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CK);
      checks++;
      if (stim !== 7'h00 || done !== 1'b1) begin
        failures++;
        $display("FAIL ncyc0_hold[%0d]: stim=%h done=%b, want 00 1", k, stim, done);
      end
    end
  endtask

  task automatic test_async_reset();
    int bc;
    logic [6:0] sg;
    resp_mode = 1'b0; resp_const = 7'h4B;
    start_run(7'h22, 20);
    repeat (5) @(negedge CK);
    checks++;
    if (busy !== 1'b1 || stim === 7'h00 || signature === 7'h00) begin
      failures++;
      $display("FAIL arst_precondition: busy=%b stim=%h sig=%h, want running", busy, stim, signature);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({stim, busy, done, signature, count} !== '0) begin
      failures++;
      $display("FAIL arst_immediate: stim=%h busy=%b done=%b sig=%h count=%0d, want all 0",
               stim, busy, done, signature, count);
    end
    @(negedge CK);
    RST = 1'b0;
    @(negedge CK);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL arst_idle: busy=%b done=%b, want 0 0", busy, done);
    end
    start_run(7'h11, 0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== '0 || signature !== 7'h00) begin
      failures++;
      $display("FAIL idle_ncyc0: done=%b busy=%b count=%0d sig=%h, want 1 0 0 00", done, busy, count, signature);
    end
    sb_load(7'h22, 3);
    start_run(7'h22, 3);
    sb_drain("post_reset", bc, sg);
  endtask

  task automatic test_back_to_back();
    int bc;
    logic [6:0] sg_warm;
    logic [6:0] sg1;
    logic [6:0] sg2;
    resp_mode = 1'b1;
    sb_load(7'h5A, 1000);
    start_run(7'h5A, 1000);
    sb_drain("warmup", bc, sg_warm);
    sb_load(7'h5A, 1000);
    start_run(7'h5A, 1000);
    sb_drain("b2b_run1", bc, sg1);
    sb_load(7'h5A, 1000);
    start_run(7'h5A, 1000);
    sb_drain("b2b_run2", bc, sg2);
    checks++;
    if (sg2 !== sg1) begin
      failures++;
      $display("FAIL b2b_repeat_sig: run2=%h run1=%h, want equal", sg2, sg1);
    end
    checks++;
    if (count !== 16'h03E8) begin
      failures++;
      $display("FAIL b2b_count: got %h want 03e8", count);
    end
  endtask

  initial begin
    test_reset();
    test_zero_resp();
    test_ones_resp();
    test_seed1_8();
    test_start_ignored();
    test_ncyc_zero();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
